// File: rtl/bitbal_pkg.sv
// Shared types, default parameters and width helpers for the bit-count scheduler.
package bitbal_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCount,
    StResult
  } bitbal_state_t;

  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefNreq  = 4;
  localparam int unsigned DefBpc   = 2;

  // Bits needed to hold a population count of a w-bit word (0..w).
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  // Bits needed for a requester index; never below one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bitbal_sched_if.sv
// Request and result bundle of the bit-count scheduler.
// Optional BITBAL_BALANCE_EN adds res_balanced to the result side.
interface bitbal_sched_if #(
  parameter int unsigned WIDTH = bitbal_pkg::DefWidth,
  parameter int unsigned NREQ  = bitbal_pkg::DefNreq
) ();
  import bitbal_pkg::*;

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam int unsigned IdW  = id_width(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_data;
  logic                  res_valid;
  logic                  res_ready;
  logic [CntW-1:0]       res_count;
  logic [IdW-1:0]        res_id;
`ifdef BITBAL_BALANCE_EN
  logic                  res_balanced;

  modport master (
    output req_valid, req_data, res_ready,
    input  req_ready, res_valid, res_count, res_id, res_balanced
  );
  modport slave (
    input  req_valid, req_data, res_ready,
    output req_ready, res_valid, res_count, res_id, res_balanced
  );
`else
  modport master (
    output req_valid, req_data, res_ready,
    input  req_ready, res_valid, res_count, res_id
  );
  modport slave (
    input  req_valid, req_data, res_ready,
    output req_ready, res_valid, res_count, res_id
  );
`endif

endinterface

// File: rtl/bitbal_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module bitbal_rr_arbiter
  import bitbal_pkg::*;
#(
  parameter  int unsigned NREQ = DefNreq,
  localparam int unsigned IdW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IdW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IdW-1:0]  grant_id
);

  logic           found;
  logic [IdW-1:0] idx;

  // Scan requesters starting at ptr; the first hit wins.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = IdW'((32'(ptr) + i) % NREQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
  end

endmodule

// File: rtl/bitbal_sched.sv
// Shared serial bit-count scheduler: round-robin accept, BPC bits per cycle,
// result returned over a valid/ready port tagged with the requester id.
// Optional BITBAL_BALANCE_EN adds a registered res_balanced flag.
module bitbal_sched
  import bitbal_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned NREQ  = DefNreq,
  parameter int unsigned BPC   = DefBpc
) (
  input  logic           clk,
  input  logic           reset,
  bitbal_sched_if.slave  bus,
  output logic           busy
);

  localparam int unsigned CntW  = cnt_width(WIDTH);
  localparam int unsigned IdW   = id_width(NREQ);
  localparam int unsigned Beats = WIDTH / BPC;
  localparam int unsigned BeatW = $clog2(Beats + 1);

  bitbal_state_t    state_q, state_d;
  logic [IdW-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]  acc_q, acc_d;
  logic [BeatW-1:0] beat_q, beat_d;
  logic [IdW-1:0]   id_q, id_d;
`ifdef BITBAL_BALANCE_EN
  logic             bal_q, bal_d;
`endif

  logic [NREQ-1:0]  grant;
  logic [IdW-1:0]   grant_id;
  logic [WIDTH-1:0] word;
  logic [CntW-1:0]  pc;
  logic [CntW-1:0]  acc_sum;

  bitbal_rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .req     (bus.req_valid),
    .ptr     (ptr_q),
    .grant   (grant),
    .grant_id(grant_id)
  );

  // Mux the granted requester's word.
  always_comb begin
    word = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) word = bus.req_data[i*WIDTH +: WIDTH];
    end
  end

  // Popcount of the low BPC bits, zero-extended to the accumulator width.
  always_comb begin
    pc = '0;
    for (int unsigned i = 0; i < BPC; i++) begin
      pc = pc + CntW'(shreg_q[i]);
    end
    acc_sum = acc_q + pc;
  end

  // Next-state logic for the accept / count / result sequence.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    shreg_d = shreg_q;
    acc_d   = acc_q;
    beat_d  = beat_q;
    id_d    = id_q;
`ifdef BITBAL_BALANCE_EN
    bal_d   = bal_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (|bus.req_valid) begin
          shreg_d = word;
          id_d    = grant_id;
          acc_d   = '0;
          beat_d  = BeatW'(Beats);
          state_d = StCount;
          ptr_d   = (32'(grant_id) == NREQ - 1) ? '0 : grant_id + IdW'(1);
        end
      end
      StCount: begin
        acc_d   = acc_sum;
        shreg_d = shreg_q >> BPC;
        beat_d  = beat_q - BeatW'(1);
`ifdef BITBAL_BALANCE_EN
        bal_d   = (acc_sum == CntW'(WIDTH / 2));
`endif
        if (beat_q == BeatW'(1)) state_d = StResult;
      end
      StResult: begin
        if (bus.res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; synchronous reset drops any in-flight word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      shreg_q <= '0;
      acc_q   <= '0;
      beat_q  <= '0;
      id_q    <= '0;
`ifdef BITBAL_BALANCE_EN
      bal_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      shreg_q <= shreg_d;
      acc_q   <= acc_d;
      beat_q  <= beat_d;
      id_q    <= id_d;
`ifdef BITBAL_BALANCE_EN
      bal_q   <= bal_d;
`endif
    end
  end

  // req_ready depends only on req_valid, ptr and state, masked during reset.
  assign bus.req_ready = (state_q == StIdle && !reset) ? grant : '0;
  assign bus.res_valid = (state_q == StResult);
  assign bus.res_count = acc_q;
  assign bus.res_id    = id_q;
`ifdef BITBAL_BALANCE_EN
  assign bus.res_balanced = bal_q;
`endif
  assign busy = (state_q != StIdle);

endmodule
